// File: rtl/adder_pkg.sv
// Shared definitions for the serial chunk adder: controller state encoding
// and default operand/chunk widths.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CHUNK = 4;

endpackage

// File: rtl/chunk_ripple_adder.sv
// Combinational CHUNK-bit ripple-carry adder built from per-bit full adders.
// Also exposes the carry into the MSB so the caller can derive signed overflow.
module chunk_ripple_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[CHUNK];
    assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder that sums WIDTH-bit operands CHUNK bits per clock.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    if (WIDTH % CHUNK != 0) begin : g_cfg_check
        $error("serial_chunk_adder: WIDTH must be an integer multiple of CHUNK");
    end

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;
    logic             carry_run;
    logic             accept;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             chunk_cmsb;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is a + ~b + 1, so the final carry reads as "no borrow".
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : c_in;
`else
    assign b_eff   = b;
    assign cin_eff = c_in;
`endif

    assign accept  = start && ((state == IDLE) || (state == DONE));
    assign a_chunk = a_lat[idx*CHUNK +: CHUNK];
    assign b_chunk = b_lat[idx*CHUNK +: CHUNK];

    chunk_ripple_adder #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry_run),
        .s    (chunk_sum),
        .cout (chunk_cout),
        .cmsb (chunk_cmsb)
    );

    // Operand latches and running carry carry no reset; they are only read in RUN.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_lat     <= a;
            b_lat     <= b_eff;
            carry_run <= cin_eff;
        end else if (state == RUN) begin
            carry_run <= chunk_cout;
        end
    end

    // busy/done are registered from the previous state, so done appears the
    // cycle after the final chunk is written and never overlaps busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            busy <= (state == RUN);
            done <= (state == DONE);
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        idx   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sum[idx*CHUNK +: CHUNK] <= chunk_sum;
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        carry    <= chunk_cout;
                        overflow <= chunk_cout ^ chunk_cmsb;
                        idx      <= '0;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Self-checking bench for serial_chunk_adder (WIDTH=16, CHUNK=4).
// Subtract-mode steps are included when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_chunk_adder;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_chunk_adder #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
`ifdef SERIAL_ADDER_SUB_EN
        .sub      (sub),
`endif
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .carry    (carry),
        .overflow (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer arithmetic, then wrap and range-check.
    task automatic model(input logic [15:0] x, input logic [15:0] y, input logic ci,
                         input logic sb, output logic [15:0] s, output logic c,
                         output logic v);
        longint ux, uy, sx, sy, u, t;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (sb) begin
            u = ux - uy;
            t = sx - sy;
            c = (ux >= uy);
        end else begin
            u = ux + uy + longint'(ci);
            t = sx + sy + longint'(ci);
            c = (u >= 65536);
        end
        s = u[15:0];
        v = (t > 32767) || (t < -32768);
    endtask

    task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic ci,
                         input logic sb);
        a    = x;
        b    = y;
        c_in = ci;
`ifdef SERIAL_ADDER_SUB_EN
        sub  = sb;
`else
        if (sb) $display("note: subtract request dropped in add-only build");
`endif
    endtask

    task automatic do_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input logic ci, input logic sb);
        int n;
        logic [15:0] es;
        logic ec, ev;
        model(x, y, ci, sb, es, ec, ev);
        @(negedge clk);
        drive(x, y, ci, sb);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 2) chk({tag, "_busy_run"}, 32'(busy), 32'd1);
        end
        chk({tag, "_latency"}, 32'(n), 32'(N + 1));
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_carry"}, 32'(carry), 32'(ec));
        chk({tag, "_ovf"}, 32'(overflow), 32'(ev));
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        int seen;
        logic [15:0] es, x, y;
        logic ec, ev, ci, sb;

        rst_n = 1'b0;
        start = 1'b1;
        drive(16'h1234, 16'h4321, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("start_in_reset_ignored", 32'(seen), 32'd0);

        do_op("basic", 16'h1234, 16'h4321, 1'b0, 1'b0);
        do_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        do_op("sovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        do_op("cin", 16'h00FF, 16'h0000, 1'b1, 1'b0);

        // Reset during the second RUN cycle abandons the operation.
        @(negedge clk);
        drive(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("midrst_no_done", 32'(seen), 32'd0);
        do_op("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0);

        // Start during RUN is ignored; start still high in DONE launches the next op.
        model(16'h1111, 16'h2222, 1'b0, 1'b0, es, ec, ev);
        @(negedge clk);
        drive(16'h1111, 16'h2222, 1'b0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        drive(16'hAAAA, 16'h0F0F, 1'b1, 1'b0);
        start = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("b2b_first_latency", 32'(n), 32'(N - 1));
        chk("b2b_first_sum", 32'(sum), 32'(es));
        chk("b2b_first_carry", 32'(carry), 32'(ec));
        model(16'hAAAA, 16'h0F0F, 1'b1, 1'b0, es, ec, ev);
        n = 0;
        @(negedge clk);
        n++;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_second_latency", 32'(n), 32'(N + 1));
        chk("b2b_second_sum", 32'(sum), 32'(es));
        chk("b2b_second_carry", 32'(carry), 32'(ec));
        chk("b2b_second_ovf", 32'(overflow), 32'(ev));

`ifdef SERIAL_ADDER_SUB_EN
        do_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1);
        do_op("sub_pos", 16'h0007, 16'h0005, 1'b0, 1'b1);
        do_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1);
`endif

        for (int i = 0; i < 24; i++) begin
            x  = 16'($urandom);
            y  = 16'($urandom);
            ci = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            sb = 1'($urandom);
`else
            sb = 1'b0;
`endif
            do_op($sformatf("rnd%0d", i), x, y, ci, sb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
